keyed_obf_fsm: RTL
==================

# keyed_obf_fsm

Parametrised key-locked controller with duplicated (decoy) state paths and a counter-triggered payload. Generalises the fixed single-key-bit, single-duplicate-state benchmark FSMs to KEY_W key-gated transitions, configurable data width, and configurable trigger threshold. Sits alongside the existing locking/trojan benchmarks as a scalable target for key-recovery and trojan-detection experiments.

## Interface
- DATA_W, 8: datapath width, ≥2
- KEY_W, 4: number of key-gated steps / key bits, ≥1
- KEY, 4'b1010: correct key, KEY_W bits; bit i gates step i
- TRIG_CNT, 5: decoy transaction index (1-based) at which the payload first fires, ≥1
- CORRUPT_MASK, all ones: XOR mask applied to dout when payload is active

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  transaction request, sampled only in IDLE
- din  in  DATA_W  operand, captured with start
- keyinput  in  KEY_W  key bits; bit i sampled at step i
- busy  out  1  high from the edge accepting start until the edge ending EMIT
- valid_out  out  1  one-cycle result strobe
- dout  out  DATA_W  result, held until next valid_out

## Operation
- States: IDLE, STEP, STEP_D, EMIT, EMIT_D; step index idx (clog2(KEY_W) bits, min 1); accumulator acc (DATA_W).
- IDLE: start=1 → acc<=din, idx<=0, go STEP; else stay.
- STEP/STEP_D at idx=i: acc <= rotl(acc,1) ^ (i+1) (constant truncated to DATA_W). Identical datapath on both paths.
- Path select: in STEP, keyinput[i]==KEY[i] → stay genuine; mismatch → STEP_D. STEP_D is sticky; keyinput ignored once in decoy.
- After step KEY_W-1: genuine → EMIT, decoy → EMIT_D; otherwise idx<=idx+1.
- EMIT: dout<=acc, valid_out<=1, go IDLE.
- EMIT_D: if decoy_cnt ≥ TRIG_CNT-1, dout<=acc^CORRUPT_MASK, else dout<=acc; valid_out<=1; decoy_cnt<=min(decoy_cnt+1, TRIG_CNT); go IDLE.
- decoy_cnt: width clog2(TRIG_CNT+1), cleared only by rst, never by genuine transactions; saturates at TRIG_CNT. Decoy transactions 1..TRIG_CNT-1 are bit-identical to genuine; transaction TRIG_CNT onward are corrupted.
- start while busy is ignored (not queued). start in the same cycle valid_out is high is accepted (state is IDLE then).
- No externally visible difference between genuine and decoy paths other than corrupted dout.

## Timing
- Reset (rst=0, async): state=IDLE, idx=0, acc=0, decoy_cnt=0, busy=0, valid_out=0, dout=0. Reset mid-transaction aborts it; no valid_out.
- start sampled at edge E0 → busy=1 after E0; step i executes at edge E0+i+1 using keyinput[i] at that edge; EMIT/EMIT_D at edge E0+KEY_W+1 drives valid_out=1 and dout for one cycle; busy=0 after that edge.
- Latency start→valid_out: KEY_W+1 cycles. Back-to-back throughput: one transaction per KEY_W+2 cycles.
- All outputs registered; no combinational input→output path.

## Structure
- Package keyed_obf_pkg: state enum, default KEY/TRIG_CNT/CORRUPT_MASK constants, round-constant function rc(i, DATA_W), rotl function.
- Sub-module obf_trig_counter: saturating decoy counter with inc input and fire output (fire = cnt ≥ TRIG_CNT-1); top holds FSM and datapath.

## Test plan
Defaults (DATA_W=8, KEY_W=4, KEY=4'b1010, TRIG_CNT=5, mask 8'hFF) unless noted.
- Correct key, din=8'h01 → valid_out exactly 5 cycles after start edge, dout=8'h12; din=8'h80 → dout=8'h0A; repeat 10× → never corrupted.
- Wrong key 4'b1011, din=8'h01, 6 transactions → dout=8'h12 on transactions 1–4, 8'hED on 5 and 6; interleaved correct-key transactions neither reset nor advance the count.
- Key mismatch only at step 3 (keyinput flipped between edges) → decoy path taken; key correct at step 0 then flipped at step 1 → decoy; restoring key later in same transaction does not return to genuine.
- start pulsed during busy → ignored, single valid_out; start held high continuously → transactions every 6 cycles.
- rst asserted mid-STEP and after 5 decoy transactions → outputs 0 immediately, no valid_out, next wrong-key transaction returns 8'h12 (counter cleared).
- Param sweep KEY_W=1 and KEY_W=8, TRIG_CNT=1 → latency KEY_W+1; TRIG_CNT=1 corrupts first decoy transaction.

Source files
------------

// File: rtl/keyed_obf_fsm_pkg.sv
// Shared types, default constants and datapath helpers for the keyed
// obfuscated controller.
//   state_e  : controller states (genuine and decoy paths)
//   rc()     : step round constant (i+1) truncated to the datapath width
//   rotl()   : rotate-left by one within the low w bits of a 64-bit word
package keyed_obf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_STEP_D,
    S_EMIT,
    S_EMIT_D
  } state_e;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_KEY_W    = 4;
  localparam int unsigned DEF_TRIG_CNT = 5;
  localparam logic [3:0]  DEF_KEY      = 4'b1010;
  localparam logic [7:0]  DEF_CORRUPT_MASK = 8'hFF;

  function automatic logic [63:0] width_mask(input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return m;
  endfunction

  function automatic logic [63:0] rc(input int unsigned i, input int unsigned w);
    return 64'(i + 1) & width_mask(w);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned w);
    return ((v << 1) | (v >> (w - 1))) & width_mask(w);
  endfunction

endpackage

// File: rtl/keyed_obf_fsm_trig_counter.sv
// Saturating counter of decoy transactions.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : one decoy transaction completes this cycle
//   fire     : count so far >= TRIG_CNT-1, i.e. the completing decoy
//              transaction is the TRIG_CNT-th or later
module obf_trig_counter
  import keyed_obf_pkg::*;
#(
  parameter int unsigned TRIG_CNT = DEF_TRIG_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic fire
);

  localparam int unsigned CNT_W = $clog2(TRIG_CNT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_W'(TRIG_CNT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compared as cnt+1 >= TRIG_CNT one bit wider so TRIG_CNT=1 needs no
  // special case and nothing overflows.
  assign fire = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(TRIG_CNT));

endmodule

// File: rtl/keyed_obf_fsm.sv
// Key-locked controller with a duplicated decoy path and a counter-
// triggered output corruption payload.
//   clk, rst  : clock, asynchronous active-low reset
//   start,din : transaction request and operand (sampled in IDLE only)
//   keyinput  : key bits, bit i sampled at step i
//   busy      : transaction in flight
//   valid_out : one-cycle result strobe
//   dout      : result, held until the next valid_out
module keyed_obf_fsm
  import keyed_obf_pkg::*;
#(
  parameter int unsigned          DATA_W       = DEF_DATA_W,
  parameter int unsigned          KEY_W        = DEF_KEY_W,
  parameter logic [KEY_W-1:0]     KEY          = KEY_W'(DEF_KEY),
  parameter int unsigned          TRIG_CNT     = DEF_TRIG_CNT,
  parameter logic [DATA_W-1:0]    CORRUPT_MASK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [KEY_W-1:0]  keyinput,
  output logic              busy,
  output logic              valid_out,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              fire;
  logic              decoy_done;

  assign decoy_done = (state_q == S_EMIT_D);

  obf_trig_counter #(
    .TRIG_CNT (TRIG_CNT)
  ) u_trig (
    .clk  (clk),
    .rst  (rst),
    .inc  (decoy_done),
    .fire (fire)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  // Next state and datapath
  logic [DATA_W-1:0] step_val;
  logic              last_step;
  logic              key_ok;
  logic              go_decoy;

  always_comb begin
    step_val  = DATA_W'(rotl(64'(acc_q), DATA_W)) ^ DATA_W'(rc(32'(idx_q), DATA_W));
    last_step = (idx_q == IDX_W'(KEY_W - 1));
    key_ok    = (keyinput[idx_q] == KEY[idx_q]);
    // Once on the decoy path the key is no longer consulted.
    go_decoy  = (state_q == S_STEP_D) || !key_ok;

    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = din;
          idx_d   = '0;
          state_d = S_STEP;
        end
      end
      S_STEP, S_STEP_D: begin
        acc_d = step_val;
        if (last_step) begin
          state_d = go_decoy ? S_EMIT_D : S_EMIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = go_decoy ? S_STEP_D : S_STEP;
        end
      end
      S_EMIT, S_EMIT_D: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Registered outputs
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_q == S_EMIT) || (state_q == S_EMIT_D);
    dout_d  = dout_q;
    if (state_q == S_EMIT) begin
      dout_d = acc_q;
    end else if (state_q == S_EMIT_D) begin
      dout_d = fire ? (acc_q ^ CORRUPT_MASK) : acc_q;
    end
  end

  assign busy      = busy_q;
  assign valid_out = valid_q;
  assign dout      = dout_q;

endmodule
